md_ctrl: RTL
============

Name: md_ctrl

Overview:
- Multi-cycle sequencer and HI/LO owner for the EX-stage multiply/divide datapath of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from EX and holds operands for a fixed per-op latency.
- Commits results into architectural HI/LO and raises a stall to the hazard unit while an MD instruction would collide with a busy unit.

Parameters:
- MUL_LAT, 5, busy cycles for mult/multu; legal range 1..15.
- DIV_LAT, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- AE  in  32  rs operand in EX.
- BE  in  32  rt operand in EX.
- mulE  in  1  mult/multu in EX.
- divE  in  1  div/divu in EX.
- unsE  in  1  1 = unsigned op (multu/divu), 0 = signed.
- mthiE  in  1  mthi in EX.
- mtloE  in  1  mtlo in EX.
- mfhiE  in  1  mfhi in EX.
- mfloE  in  1  mflo in EX.
- flushE  in  1  EX instruction squashed this cycle.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- busy  out  1  operation in flight.
- stallE  out  1  freeze IF/ID/EX, bubble into MEM.
- done  out  1  one-cycle pulse, the cycle after commit.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, stallE=0, held operands cleared. Reset mid-operation discards the operation; HI/LO go to 0.
- mdE = mulE|divE|mthiE|mtloE|mfhiE|mfloE. At most one is high per cycle; multiple high is illegal and unchecked.
- stallE = busy & mdE & ~flushE (combinational). Non-MD instructions never stall.
- start = (mulE|divE) & ~busy & ~flushE.
  - On start: latch AE, BE, unsE, op; load cnt with MUL_LAT or DIV_LAT; go to RUN.
  - The start instruction itself never stalls.
- RUN:
  - busy=1 for exactly LAT cycles following the start cycle; cnt decrements each cycle.
  - On the edge ending the cycle where cnt==1: HI/LO take the computed result, state returns to IDLE.
  - In the next cycle busy=0 and done=1. An MD instruction stalled behind the operation proceeds in that cycle.
- mthi/mtlo when ~busy & ~flushE: hi (resp. lo) <= AE at the end of that cycle. The other register is unchanged.
- mfhi/mflo: hi/lo are always the committed values, read combinationally by the EX forwarding mux. Stalled while busy, so they never see stale data.
- flushE suppresses start, mthi and mtlo in that cycle. It does not abort an operation already in RUN.
- Arithmetic on the latched operands:
  - mult: {HI,LO} = 64-bit signed product.
  - multu: {HI,LO} = 64-bit unsigned product.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned LO = quotient, HI = remainder.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero, both signed and unsigned: LO=0xFFFFFFFF, HI=dividend. The operation still takes the full DIV_LAT and raises no exception.
- Back-to-back: a mult in the cycle busy falls is a new start. It produces zero idle cycles between done and the new busy.

Decomposition:
- Shared package md_pkg:
  - op encoding (MD_MUL, MD_DIV) and state encoding (IDLE, RUN);
  - MUL_LAT/DIV_LAT defaults;
  - div-by-zero constant 32'hFFFF_FFFF.
- One sub-module, md_arith: purely combinational. Inputs are the latched a, b, uns, op; outputs are res_hi, res_lo. It contains sign handling and the zero-divisor override. md_ctrl owns the FSM, counter, stall and HI/LO registers.

Test Plan:
- Reset low for 3 cycles, release -> hi=lo=0, busy=stallE=done=0; mthiE with AE=0x12345678 -> hi=0x12345678 next cycle, lo=0.
- mulE, unsE=0, AE=0xFFFFFFFE, BE=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle. Repeat with unsE=1 -> hi=0x00000002, lo=0xFFFFFFFA.
- divE, unsE=0, AE=0xFFFFFFF9 (-7), BE=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with BE=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF9.
- mult start, then mfloE held on the next cycle -> stallE=1 for 5 cycles (cycle after start through the last busy cycle), 0 in the done cycle with lo already updated.
- mulE with flushE=1 -> no busy, hi/lo unchanged. divE started, flushE pulsed mid-RUN -> operation completes normally.
- divE started, rst_n pulsed low at busy cycle 4 -> busy, hi, lo=0 immediately; no done pulse follows.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit.
package md_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Operands captured at start and held for the whole operation
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            uns;
    md_op_e          op;
  } md_req_t;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide on the held operands, including sign
// handling and the zero-divisor override.
module md_arith
  import md_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            uns,
  input  md_op_e          op,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  logic            sgn;
  logic [63:0]     a_ext;
  logic [63:0]     b_ext;
  logic [63:0]     prod;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  // Product: the low 64 bits of the extended operands give the exact result
  always_comb begin
    sgn   = ~uns;
    a_ext = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    b_ext = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    prod  = a_ext * b_ext;
  end

  // Divide on magnitudes, then restore signs (0x80000000 / -1 wraps to itself)
  always_comb begin
    a_mag = (sgn & a[31]) ? XLEN'(-a) : a;
    b_mag = (sgn & b[31]) ? XLEN'(-b) : b;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    quo   = (sgn & (a[31] ^ b[31])) ? XLEN'(-q_mag) : q_mag;
    rem   = (sgn & a[31]) ? XLEN'(-r_mag) : r_mag;
  end

  // Select result; a zero divisor returns all-ones quotient and the dividend
  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (op == MD_DIV) begin
      if (b == '0) begin
        res_hi = a;
        res_lo = DIV_ZERO_Q;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle mult/div sequencer owning architectural HI/LO.
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] AE,
  input  logic [XLEN-1:0] BE,
  input  logic            mulE,
  input  logic            divE,
  input  logic            unsE,
  input  logic            mthiE,
  input  logic            mtloE,
  input  logic            mfhiE,
  input  logic            mfloE,
  input  logic            flushE,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stallE,
  output logic            done
);

  md_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  md_req_t         req, req_n;
  logic [XLEN-1:0] hi_n, lo_n;
  logic            busy_n, done_n;
  logic            md_e, start;
  logic [XLEN-1:0] res_hi, res_lo;

  md_arith u_arith (
    .a      (req.a),
    .b      (req.b),
    .uns    (req.uns),
    .op     (req.op),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Hazard-unit stall and start qualification
  always_comb begin
    md_e   = mulE | divE | mthiE | mtloE | mfhiE | mfloE;
    stallE = busy & md_e & ~flushE;
    start  = (mulE | divE) & ~busy & ~flushE;
  end

  // State register and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      req   <= req_n;
      hi    <= hi_n;
      lo    <= lo_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state: start/moves in IDLE, countdown and commit in RUN
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req;
    hi_n    = hi;
    lo_n    = lo;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          req_n.a   = AE;
          req_n.b   = BE;
          req_n.uns = unsE;
          req_n.op  = divE ? MD_DIV : MD_MUL;
          cnt_n     = divE ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          state_n   = RUN;
          busy_n    = 1'b1;
        end else if (!flushE) begin
          if (mthiE) hi_n = AE;
          if (mtloE) lo_n = AE;
        end
      end
      RUN: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hi_n    = res_hi;
          lo_n    = res_lo;
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
